// File: rtl/decode_stage.sv
// Decode stage: field extraction, 2R1W register file, EX/WB operand forwarding,
// and the registered ID/EX boundary that feeds the execute stage.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] ex_result,
  output logic            out_valid,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [2:0]      alu_op,
  output logic [RW-1:0]   rd,
  output logic            rd_we
);

  logic [XLEN-1:0] regs_r [NREG];

  logic [2:0]      id_alu_op_s;
  logic [RW-1:0]   id_rd_s;
  logic [RW-1:0]   id_rs1_s;
  logic [RW-1:0]   id_rs2_s;
  logic            id_we_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic            unused_instr_s;

  // Priority: x0, then the instruction currently in EX, then the write-back in flight, then the file.
  function automatic logic [XLEN-1:0] select_operand(
    input logic [RW-1:0]   rs,
    input logic            ex_fwd_en,
    input logic [RW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_en,
    input logic [RW-1:0]   wb_dst,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] res;
    if (rs == {RW{1'b0}}) begin
      res = {XLEN{1'b0}};
    end else if (ex_fwd_en && (ex_rd == rs)) begin
      res = ex_val;
    end else if (wb_en && (wb_dst == rs)) begin
      res = wb_val;
    end else begin
      res = rf_val;
    end
    return res;
  endfunction

  assign id_alu_op_s    = instr[31:29];
  assign id_rd_s        = instr[28:24];
  assign id_rs1_s       = instr[23:19];
  assign id_rs2_s       = instr[18:14];
  assign id_we_s        = instr[13];
  assign unused_instr_s = ^instr[12:0];

  // Operand selection; rd_we is already gated by out_valid, so bubbles never forward.
  always_comb begin
    rs1_val_s = select_operand(id_rs1_s, out_valid && rd_we, rd, ex_result,
                               wb_we, wb_rd, wb_data, regs_r[id_rs1_s]);
    rs2_val_s = select_operand(id_rs2_s, out_valid && rd_we, rd, ex_result,
                               wb_we, wb_rd, wb_data, regs_r[id_rs2_s]);
  end

  // Register file write port; stall and flush never block write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wb_we && (wb_rd != {RW{1'b0}})) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  // ID/EX boundary register: flush beats stall, stall holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rs1_data  <= {XLEN{1'b0}};
      rs2_data  <= {XLEN{1'b0}};
      alu_op    <= 3'd0;
      rd        <= {RW{1'b0}};
      rd_we     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      rd_we     <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      rd_we     <= id_we_s && in_valid;
      rs1_data  <= rs1_val_s;
      rs2_data  <= rs2_val_s;
      alu_op    <= id_alu_op_s;
      rd        <= id_rd_s;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts each ID/EX
// result when stimulus is applied; the prediction is popped after the edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] ex_result;
  logic        out_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [2:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        dchk;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  logic [31:0] m_regs [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_result(ex_result), .out_valid(out_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_op(alu_op),
    .rd(rd), .rd_we(rd_we)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic we);
    return {op, d, s1, s2, we, 13'h1abc};
  endfunction

  function automatic logic [31:0] sel(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (m.v && m.we && (m.rd == rs)) return ex_result;
    if (wb_we && (wb_rd == rs)) return wb_data;
    return m_regs[rs];
  endfunction

  task automatic model_reset();
    m = '{v: 1'b0, a: 32'd0, b: 32'd0, op: 3'd0, rd: 5'd0, we: 1'b0, dchk: 1'b1};
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, ".rs1"}, rs1_data, 32'd0);
    check_val({tag, ".rs2"}, rs2_data, 32'd0);
    check_val({tag, ".op"}, {29'd0, alu_op}, 32'd0);
    check_val({tag, ".rd"}, {27'd0, rd}, 32'd0);
    check_val({tag, ".rd_we"}, {31'd0, rd_we}, 32'd0);
  endtask

  // Predict, advance one clock, then pop and compare; inputs stay as the caller left them.
  task automatic step(input string tag);
    exp_t e;
    if (flush) begin
      e = m; e.v = 1'b0; e.we = 1'b0; e.dchk = 1'b0;
    end else if (stall) begin
      e = m;
    end else begin
      e.v = in_valid; e.we = instr[13] && in_valid; e.op = instr[31:29];
      e.rd = instr[28:24]; e.a = sel(instr[23:19]); e.b = sel(instr[18:14]);
      e.dchk = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.v});
    check_val({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, e.we});
    if (e.dchk) begin
      check_val({tag, ".rs1"}, rs1_data, e.a);
      check_val({tag, ".rs2"}, rs2_data, e.b);
      check_val({tag, ".op"}, {29'd0, alu_op}, {29'd0, e.op});
      check_val({tag, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
    end
    m = e;
    if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic w,
                       input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] ex);
    in_valid = v; instr = ins; wb_we = w; wb_rd = wr; wb_data = wd; ex_result = ex;
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    model_reset();
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: every register reads zero after reset, then a written value reads back
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, mk(3'(i), 5'd0, 5'(i), 5'(31 - i), 1'b0), 1'b0, 5'd0, 32'd0, $urandom);
      step("rf_zero");
    end
    drive(1'b0, 32'd0, 1'b1, 5'd5, 32'h1234, 32'd0);
    step("wb_x5");
    drive(1'b1, mk(3'd1, 5'd9, 5'd5, 5'd0, 1'b0), 1'b0, 5'd0, 32'd0, 32'd0);
    step("read_x5");
    check_val("read_x5.direct", rs1_data, 32'h1234);

    // 2: x0 is never written and never forwarded
    drive(1'b0, 32'd0, 1'b1, 5'd0, 32'hffff_ffff, 32'd0);
    step("wb_x0");
    drive(1'b1, mk(3'd2, 5'd0, 5'd0, 5'd5, 1'b1), 1'b0, 5'd0, 32'd0, 32'd0);
    step("rd_x0");
    drive(1'b1, mk(3'd3, 5'd4, 5'd0, 5'd0, 1'b0), 1'b0, 5'd0, 32'd0, 32'haa);
    step("fwd_x0");
    check_val("fwd_x0.direct", rs1_data, 32'd0);

    // 3: EX forwarding, including priority over a simultaneous write-back
    drive(1'b0, 32'd0, 1'b1, 5'd3, 32'h10, 32'd0);
    step("wb_x3");
    drive(1'b1, mk(3'd0, 5'd3, 5'd1, 5'd2, 1'b1), 1'b0, 5'd0, 32'd0, 32'd0);
    step("add_x3");
    drive(1'b1, mk(3'd4, 5'd3, 5'd3, 5'd6, 1'b1), 1'b0, 5'd0, 32'd0, 32'h77);
    step("ex_fwd");
    check_val("ex_fwd.direct", rs1_data, 32'h77);
    drive(1'b1, mk(3'd5, 5'd8, 5'd3, 5'd3, 1'b0), 1'b1, 5'd3, 32'h55, 32'h77);
    step("ex_over_wb");
    check_val("ex_over_wb.direct", rs2_data, 32'h77);

    // 4: write-through bypass in the issue cycle
    drive(1'b1, mk(3'd6, 5'd10, 5'd3, 5'd7, 1'b1), 1'b1, 5'd7, 32'h99, 32'h0);
    step("wb_bypass");
    check_val("wb_bypass.direct", rs2_data, 32'h99);

    // 5: stall holds captured operands; a WB during the stall lands in the file
    drive(1'b1, mk(3'd7, 5'd11, 5'd2, 5'd7, 1'b1), 1'b0, 5'd0, 32'd0, 32'h5);
    step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(3'd1, 5'd12, 5'd2, 5'd2, 1'b1), i == 1, 5'd2, 32'hbeef, 32'h66);
      stall = 1'b1;
      step("stall");
    end
    drive(1'b1, mk(3'd2, 5'd13, 5'd2, 5'd11, 1'b1), 1'b0, 5'd0, 32'd0, 32'h123);
    step("post_stall");
    check_val("post_stall.x2", rs1_data, 32'hbeef);
    drive(1'b1, mk(3'd3, 5'd2, 5'd5, 5'd5, 1'b1), 1'b0, 5'd0, 32'd0, 32'h321);
    stall = 1'b1; flush = 1'b1;
    step("stall_flush");
    drive(1'b1, mk(3'd4, 5'd14, 5'd13, 5'd13, 1'b0), 1'b0, 5'd0, 32'd0, 32'hdead);
    step("bubble_nofwd");
    drive(1'b1, mk(3'd5, 5'd15, 5'd14, 5'd2, 1'b1), 1'b0, 5'd0, 32'd0, 32'h1);
    flush = 1'b1;
    step("flush_only");
    drive(1'b0, mk(3'd5, 5'd15, 5'd2, 5'd2, 1'b1), 1'b0, 5'd0, 32'd0, 32'h1);
    step("invalid_issue");

    // 6: asynchronous reset between edges clears outputs and the file
    drive(1'b1, mk(3'd6, 5'd16, 5'd5, 5'd7, 1'b1), 1'b0, 5'd0, 32'd0, 32'h44);
    step("b2b_a");
    drive(1'b1, mk(3'd7, 5'd17, 5'd16, 5'd2, 1'b1), 1'b1, 5'd20, 32'h2020, 32'h45);
    step("b2b_b");
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    #1;
    rst = 1'b0;
    drive(1'b1, mk(3'd1, 5'd18, 5'd5, 5'd20, 1'b1), 1'b0, 5'd0, 32'd0, 32'h99);
    step("after_rst");
    check_val("after_rst.x5", rs1_data, 32'd0);
    check_val("after_rst.x20", rs2_data, 32'd0);
    drive(1'b1, mk(3'd2, 5'd19, 5'd18, 5'd7, 1'b0), 1'b0, 5'd0, 32'd0, 32'h5a5a);
    step("after_rst_fwd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Pipeline stage directly upstream of the execute stage. It decodes a 32-bit instruction and reads two operands from an internal register file. It resolves RAW hazards by forwarding from the execute result and from the write-back port. Its outputs go into a registered ID/EX boundary that drives the execute stage's rs1_data, rs2_data and alu_op inputs.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers; index width RW = clog2(NREG) = 5; register 0 is hardwired to zero

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instr is a valid instruction this cycle
instr  input  32  instruction word
stall  input  1  hold ID/EX register contents
flush  input  1  squash: load a bubble into ID/EX
wb_we  input  1  write-back write enable
wb_rd  input  RW  write-back destination register
wb_data  input  XLEN  write-back data
ex_result  input  XLEN  current execute-stage result, combinational from this block's outputs
out_valid  output  1  ID/EX holds a valid instruction
rs1_data  output  XLEN  operand A to execute
rs2_data  output  XLEN  operand B to execute
alu_op  output  3  ALU opcode to execute
rd  output  RW  destination register
rd_we  output  1  instruction writes rd

Behaviour:
- Instruction fields:
  - alu_op = instr[31:29]
  - rd = instr[28:24]
  - rs1 = instr[23:19]
  - rs2 = instr[18:14]
  - we = instr[13]
  - instr[12:0] is ignored.
- Register file:
  - NREG x XLEN, one synchronous write port (wb_*), two combinational read ports.
  - Writes to register 0 are discarded; reads of register 0 always return 0.
  - Async reset clears all registers to 0.
- Operand select for each source rs, in priority order:
  1. rs == 0 -> 0.
  2. out_valid && rd_we && rd == rs -> ex_result (EX forward).
  3. wb_we && wb_rd == rs -> wb_data (same-cycle write-through bypass).
  4. Otherwise -> register file contents.
- ID/EX register, updated on the rising clock edge:
  - rst: out_valid=0, rs1_data=0, rs2_data=0, alu_op=0, rd=0, rd_we=0, taking effect immediately (asynchronous).
  - flush, which has priority over stall: out_valid<=0 and rd_we<=0; the data fields may keep their old values.
  - stall && !flush: all outputs hold their values.
  - Otherwise: out_valid<=in_valid; rd_we<=we&&in_valid; the data fields load the decoded and forwarded values.
- Register-file writes are never blocked by stall or flush.
- Latency: one cycle from instr to outputs. Throughput: one instruction per cycle when not stalled.
- Bubbles (out_valid=0) never forward: the rd_we gating guarantees this.
- A held (stalled) instruction keeps its captured operands. A later write-back to its source registers does not update the held operands.
- rst asserted mid-operation: everything clears at once. After rst deasserts, the first clock edge with in_valid captures a fresh instruction.

Test Plan:
1. Reset then read: assert rst; x1..x31 read 0, all outputs 0. Write x5=0x1234 via WB, then issue rs1=5, rs2=0 -> next cycle rs1_data=0x1234, rs2_data=0, out_valid=1.
2. x0 protection: WB writes x0=0xFFFFFFFF; then issue rs1=0 -> rs1_data=0. Issue rd=0 with we=1, with ex_result=0xAA on the following instruction reading rs1=0 -> rs1_data=0.
3. EX forward: issue add rd=3, then immediately rs1=3 with ex_result=0x77 while x3=0x10 in the file -> rs1_data=0x77. Same case with WB also writing x3=0x55 in that cycle -> still 0x77 (EX priority).
4. WB bypass: WB writes x7=0x99 in the same cycle as an issue reading rs2=7 -> rs2_data=0x99, with no extra cycle of latency.
5. Stall/flush: stall for 3 cycles -> outputs are constant, and a WB to x2 during the stall is visible afterwards. Assert stall and flush together -> next cycle out_valid=0 and rd_we=0. A subsequent instruction reading that bubble's rd gets the register file value, not ex_result.
6. Async reset mid-stream: issue back-to-back valid instructions and assert rst between clock edges -> outputs go to 0 before the next edge. The register file is cleared. Normal issue resumes on the first edge after release.
